// File: rtl/instruction_loader.sv
// ============================================================================
// Module      : instruction_loader
// Description : Assembles a big-endian byte stream into 32-bit words and
//               writes them to instruction memory until a halt word is seen
//               or memory is full. Optional o_checksum via LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_loader #(
    parameter int              NB        = 32,
    parameter int              TAM_I     = 256,
    parameter logic [NB-1:0]   HALT_CODE = 32'hFFFFFFFF
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic          i_byte_valid,
    input  logic [7:0]    i_byte,
    output logic          o_byte_ready,
    output logic          o_instruction_write_enable,
    output logic [NB-1:0] o_instruction_address,
    output logic [NB-1:0] o_instruction_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_overflow,
`ifdef LOADER_CHECKSUM_EN
    output logic [NB-1:0] o_checksum,
`endif
    output logic [NB-1:0] o_word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [NB-1:0] LAST_ADDR = NB'(TAM_I - 4);
    localparam logic [NB-1:0] WORD_STEP = NB'(4);

    state_t        state;
    state_t        next_state;
    logic [1:0]    byte_idx;
    logic [NB-1:0] data_reg;
    logic [NB-1:0] addr;
    logic [NB-1:0] word_count;
    logic          overflow;
    logic          byte_xfer;
    logic          start_accept;
    logic          is_halt;
    logic          is_last;
`ifdef LOADER_CHECKSUM_EN
    logic [NB-1:0] checksum;
`endif

    assign byte_xfer    = (state == RECV) && i_byte_valid;
    assign start_accept = i_start && ((state == IDLE) || (state == DONE));
    assign is_halt      = (data_reg == HALT_CODE);
    assign is_last      = (addr == LAST_ADDR);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state                 = state;
        o_byte_ready               = 1'b0;
        o_instruction_write_enable = 1'b0;
        o_busy                     = 1'b0;
        o_done                     = 1'b0;
        case (state)
            IDLE: begin
                if (i_start) next_state = RECV;
            end
            RECV: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid && (byte_idx == 2'd3)) next_state = WRITE;
            end
            WRITE: begin
                o_instruction_write_enable = 1'b1;
                o_busy                     = 1'b1;
                next_state = (is_halt || is_last) ? DONE : RECV;
            end
            DONE: begin
                o_done = 1'b1;
                if (i_start) next_state = RECV;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_idx   <= 2'd0;
            data_reg   <= '0;
            addr       <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            checksum   <= '0;
`endif
        end else begin
            if (start_accept) begin
                byte_idx   <= 2'd0;
                addr       <= '0;
                word_count <= '0;
                overflow   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
                checksum   <= '0;
`endif
            end
            if (byte_xfer) begin
                data_reg <= {data_reg[NB-9:0], i_byte};
                byte_idx <= byte_idx + 2'd1;
            end
            // byte_idx has already wrapped to 0 after the 4th byte
            if (state == WRITE) begin
                word_count <= word_count + NB'(1);
`ifdef LOADER_CHECKSUM_EN
                checksum   <= checksum ^ data_reg;
`endif
                if (!is_halt) begin
                    if (is_last) overflow <= 1'b1;
                    else         addr     <= addr + WORD_STEP;
                end
            end
        end
    end

    assign o_instruction_address = addr;
    assign o_instruction_data    = data_reg;
    assign o_overflow            = overflow;
    assign o_word_count          = word_count;
`ifdef LOADER_CHECKSUM_EN
    assign o_checksum            = checksum;
`endif

endmodule

`default_nettype wire

// File: tb/tb_instruction_loader.sv
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed self-checking bench for instruction_loader (TAM_I=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [31:0] word_count;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] log_addr[$];
    logic [31:0] log_data[$];

    always #5 clk = ~clk;

    instruction_loader #(.NB(32), .TAM_I(16), .HALT_CODE(32'hFFFFFFFF)) dut (
        .i_clk                      (clk),
        .i_reset                    (rst),
        .i_start                    (start),
        .i_byte_valid               (byte_valid),
        .i_byte                     (byte_in),
        .o_byte_ready               (byte_ready),
        .o_instruction_write_enable (we),
        .o_instruction_address      (addr),
        .o_instruction_data         (data),
        .o_busy                     (busy),
        .o_done                     (done),
        .o_overflow                 (overflow),
`ifdef LOADER_CHECKSUM_EN
        .o_checksum                 (checksum),
`endif
        .o_word_count               (word_count)
    );

    always @(negedge clk) begin
        if (we) begin
            log_addr.push_back(addr);
            log_data.push_back(data);
        end
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk); byte_in = b; byte_valid = 1'b1;
        while (!byte_ready && n < 20) begin
            @(negedge clk); n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL send_byte_timeout: byte_ready=%0b required=1", byte_ready);
        end
        @(posedge clk); #1; byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic check_log(input string name, input int idx,
                             input logic [31:0] ea, input logic [31:0] ed);
        checks++;
        if (log_addr.size() <= idx) begin
            errors++;
            $display("FAIL %s: write %0d missing (writes=%0d)", name, idx, log_addr.size());
        end else if (log_addr[idx] !== ea || log_data[idx] !== ed) begin
            errors++;
            $display("FAIL %s: got addr=%h data=%h required addr=%h data=%h",
                     name, log_addr[idx], log_data[idx], ea, ed);
        end
    endtask

    task automatic check_status(input string name, input logic ed, input logic eo,
                                input logic [31:0] ec, input logic eb);
        checks++;
        if (done !== ed || overflow !== eo || word_count !== ec || busy !== eb) begin
            errors++;
            $display("FAIL %s: done=%b ovf=%b count=%0d busy=%b required %b %b %0d %b",
                     name, done, overflow, word_count, busy, ed, eo, ec, eb);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if ({byte_ready, we, addr, data, busy, done, overflow, word_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b we=%b addr=%h data=%h busy=%b done=%b ovf=%b cnt=%0d required all 0",
                     byte_ready, we, addr, data, busy, done, overflow, word_count);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: got %b required 0", byte_ready);
        end
    endtask

    task automatic test_basic_load();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'h20); send_byte(8'h11); send_byte(8'h00);
        send_byte(8'h0A);
        checks++;
        if (we !== 1'b1 || addr !== 32'h0 || data !== 32'h2011000A) begin
            errors++;
            $display("FAIL write_latency: we=%b addr=%h data=%h required 1 0 2011000a", we, addr, data);
        end
        send_word(32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        check_log("basic_w0", 0, 32'h0, 32'h2011000A);
        check_log("basic_w1", 1, 32'h4, 32'hFFFFFFFF);
        check_status("basic_status", 1'b1, 1'b0, 32'd2, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'hDFEEFFF5) begin
            errors++;
            $display("FAIL basic_checksum: got %h required dfeefff5", checksum);
        end
`endif
    endtask

    task automatic test_stall();
        logic [31:0] words[2];
        words[0] = 32'h2011000A; words[1] = 32'hFFFFFFFF;
        log_addr.delete(); log_data.delete();
        pulse_start();
        foreach (words[w]) begin
            for (int i = 3; i >= 0; i--) begin
                send_byte(words[w][i*8 +: 8]);
                if (i != 0) begin
                    for (int k = 0; k < 3; k++) begin
                        @(negedge clk);
                        checks++;
                        if (byte_ready !== 1'b1 || we !== 1'b0) begin
                            errors++;
                            $display("FAIL stall_ready: ready=%b we=%b required 1 0", byte_ready, we);
                        end
                    end
                end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (log_addr.size() != 2) begin
            errors++;
            $display("FAIL stall_count: got %0d writes required 2", log_addr.size());
        end
        check_log("stall_w0", 0, 32'h0, 32'h2011000A);
        check_log("stall_w1", 1, 32'h4, 32'hFFFFFFFF);
        check_status("stall_status", 1'b1, 1'b0, 32'd2, 1'b0);
    endtask

    task automatic test_overflow();
        logic [31:0] words[4];
        words[0] = 32'h01020304; words[1] = 32'h11121314;
        words[2] = 32'h21222324; words[3] = 32'h31323334;
        log_addr.delete(); log_data.delete();
        pulse_start();
        foreach (words[w]) send_word(words[w]);
        repeat (2) @(negedge clk);
        foreach (words[w]) check_log("ovf_write", w, 32'(w * 4), words[w]);
        check_status("ovf_status", 1'b1, 1'b1, 32'd4, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'h00000000) begin
            errors++;
            $display("FAIL ovf_checksum: got %h required 00000000", checksum);
        end
`endif
        byte_in = 8'h55; byte_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL ovf_ready: got %b required 0", byte_ready);
            end
        end
        byte_valid = 1'b0;
        checks++;
        if (log_addr.size() != 4) begin
            errors++;
            $display("FAIL ovf_extra_write: got %0d writes required 4", log_addr.size());
        end
    endtask

    task automatic test_reset_midword();
        log_addr.delete(); log_data.delete();
        pulse_start();
        send_byte(8'hAA); send_byte(8'hBB);
        @(negedge clk); rst = 1'b1; #1;
        checks++;
        if ({byte_ready, we, addr, data, busy, done, overflow, word_count} !== '0) begin
            errors++;
            $display("FAIL midword_reset: we=%b addr=%h data=%h busy=%b done=%b cnt=%0d required all 0",
                     we, addr, data, busy, done, word_count);
        end
        @(negedge clk); rst = 1'b0;
        pulse_start();
        send_word(32'h12345678);
        repeat (2) @(negedge clk);
        checks++;
        if (log_addr.size() != 1) begin
            errors++;
            $display("FAIL midword_count: got %0d writes required 1", log_addr.size());
        end
        check_log("midword_w0", 0, 32'h0, 32'h12345678);
        check_status("midword_status", 1'b0, 1'b0, 32'd1, 1'b1);
    endtask

    task automatic test_start_midword();
        send_byte(8'hDE); send_byte(8'hAD);
        pulse_start();
        send_byte(8'hBE); send_byte(8'hEF);
        repeat (2) @(negedge clk);
        check_log("start_mid_w1", 1, 32'h4, 32'hDEADBEEF);
        check_status("start_mid_status", 1'b0, 1'b0, 32'd2, 1'b1);
        send_word(32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        check_log("start_mid_halt", 2, 32'h8, 32'hFFFFFFFF);
        check_status("start_mid_done", 1'b1, 1'b0, 32'd3, 1'b0);
    endtask

    task automatic test_restart();
        log_addr.delete(); log_data.delete();
        pulse_start();
        check_status("restart_cleared", 1'b0, 1'b0, 32'd0, 1'b1);
        send_word(32'hFFFFFFFF);
        repeat (2) @(negedge clk);
        checks++;
        if (log_addr.size() != 1) begin
            errors++;
            $display("FAIL restart_count: got %0d writes required 1", log_addr.size());
        end
        check_log("restart_w0", 0, 32'h0, 32'hFFFFFFFF);
        check_status("restart_status", 1'b1, 1'b0, 32'd1, 1'b0);
`ifdef LOADER_CHECKSUM_EN
        checks++;
        if (checksum !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL restart_checksum: got %h required ffffffff", checksum);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_stall();
        test_overflow();
        test_reset_midword();
        test_start_midword();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instruction_loader.md
Name: instruction_loader

Overview:
Debug-side writer for the fetch stage's instruction memory load port. Accepts a byte stream (e.g. from the debug UART receiver), assembles 32-bit instruction words and issues one write per word on the write-enable/address/data port. Loading stops on a halt word or when memory is full. The block sits between the UART RX path and the fetch stage, and the debug unit releases the pipeline only after loading completes.

Parameters:
NB, 32, instruction word and address width
TAM_I, 256, instruction memory size in bytes; a power of two and a multiple of 4
HALT_CODE, 32'hFFFFFFFF, word that terminates loading

Ports:
i_clk  input  1  system clock
i_reset  input  1  asynchronous reset, active-high
i_start  input  1  single-cycle pulse that starts a new load; honoured only in IDLE or DONE
i_byte_valid  input  1  a byte is presented on i_byte
i_byte  input  8  stream byte, most-significant byte of each word first
o_byte_ready  output  1  loader accepts i_byte this cycle
o_instruction_write_enable  output  1  one-cycle write strobe to instruction memory
o_instruction_address  output  NB  byte address of the write, word aligned
o_instruction_data  output  NB  assembled instruction word
o_busy  output  1  high in RECV and WRITE
o_done  output  1  load finished; held high until next i_start or reset
o_overflow  output  1  load ended because memory was full, not because of the halt word
o_word_count  output  NB  number of words written in the current load

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All outputs 0, byte index 0, assembly register 0.
- FSM states: IDLE, RECV, WRITE, DONE.
- IDLE: o_byte_ready=0. i_start -> RECV, and the address, word count, byte index, o_done and o_overflow are all cleared.
- RECV: o_byte_ready=1. A byte transfers when i_byte_valid & o_byte_ready are both high.
  - Each transfer shifts the assembly register: data <= {data[NB-9:0], i_byte}.
  - The byte index counts 0..3. The transfer at index 3 moves the FSM to WRITE on the next edge.
  - Bytes presented with i_byte_valid=0 are ignored. There is no timeout.
- WRITE: exactly one cycle.
  - o_instruction_write_enable=1, o_byte_ready=0. Address and data outputs are stable for the whole cycle.
  - The first word of a load is written at address 0.
  - o_word_count increments at the end of the cycle.
  - Next state:
    - data==HALT_CODE -> DONE, o_overflow=0. The halt word itself is written.
    - else, address+4 == TAM_I -> DONE, o_overflow=1. No wrap-around.
    - else -> RECV with address += 4 and byte index 0.
- DONE: o_done=1, o_byte_ready=0. Incoming bytes are ignored and not consumed. i_start -> RECV with all counters cleared, same as from IDLE.
- i_start during RECV or WRITE is ignored.
- o_instruction_write_enable is never high outside WRITE.
- Latency: the write strobe occurs 1 cycle after the 4th byte is accepted.
- Throughput: at most one word per 5 cycles.
- A reset asserted mid-word discards the partial word. No write is issued.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined: adds output o_checksum (NB bits). It is the XOR of every word written in the current load, including the halt word. Cleared on reset and on an accepted i_start. Updated in the same edge as o_word_count.
- Not defined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset then i_start; stream 20 11 00 0A, then FF FF FF FF -> two write strobes: addr 0 data 0x2011000A, then addr 4 data 0xFFFFFFFF. Then o_done=1, o_overflow=0, o_word_count=2.
- Same stream with i_byte_valid low for 3 cycles between bytes -> identical writes. o_byte_ready stays 1 in RECV and no extra strobes occur.
- TAM_I=16, stream 4 non-halt words -> writes at 0, 4, 8, 12. Then o_done=1, o_overflow=1; a 5th word's bytes are not accepted (o_byte_ready=0).
- Assert i_reset after 2 bytes of a word -> all outputs 0 immediately, no strobe. A new i_start plus 4 bytes writes at address 0.
- After DONE, pulse i_start and send FF FF FF FF -> o_done clears, single write at addr 0, o_word_count=1. With LOADER_CHECKSUM_EN, o_checksum=0xFFFFFFFF.
- i_start pulsed mid-word in RECV -> ignored; the word completes at the expected address.
